// File: rtl/avmm_bridge_pkg.sv
// Shared types and helpers for the Avalon-MM burst bridge.
package avmm_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_BEAT  = 3'd1,
    ST_WR_WAIT  = 3'd2,
    ST_RD_ISSUE = 3'd3,
    ST_RD_DRAIN = 3'd4
  } state_e;

  // Byte address increment between consecutive beats.
  function automatic int unsigned beat_bytes(input int unsigned data_w);
    return data_w / 8;
  endfunction

  // Largest legal burst length for a given burstcount width.
  function automatic int unsigned burst_max(input int unsigned burst_w);
    return 32'd1 << (burst_w - 1);
  endfunction

  // Counter width able to hold 0..max_val inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return $clog2(max_val + 32'd1);
  endfunction

endpackage

// File: rtl/avmm_pending_counter.sv
// Saturating up/down count of master-side reads in flight, with a
// look-ahead limit flag so the issue logic can register m0_read.
module avmm_pending_counter
  import avmm_bridge_pkg::*;
#(
  parameter int unsigned MAX_PENDING = 4,
  localparam int unsigned CNT_W = cnt_width(MAX_PENDING)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] count_o,
  output logic             limit_next_c_o
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_PENDING);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: simultaneous inc/dec cancel; clamp at 0 and at the limit.
  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_i) begin
      if (count_q != MAX_C) count_d = count_q + CNT_W'(1);
    end else if (dec_i && !inc_i) begin
      if (count_q != '0) count_d = count_q - CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o        = count_q;
  assign limit_next_c_o = (count_d == MAX_C);

endmodule

// File: rtl/avmm_burst_bridge.sv
// Avalon-MM bridge: accepts bursting slave reads/writes and replays them as
// single-beat master transfers with incrementing, wrapping addresses.
module avmm_burst_bridge
  import avmm_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned BURST_W     = 4,
  parameter int unsigned MAX_PENDING = 4
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic [ADDR_W-1:0]   s0_address,
  input  logic [BURST_W-1:0]  s0_burstcount,
  input  logic                s0_read,
  input  logic                s0_write,
  input  logic [DATA_W-1:0]   s0_writedata,
  input  logic [DATA_W/8-1:0] s0_byteenable,
  input  logic                s0_debugaccess,
  output logic                s0_waitrequest,
  output logic [DATA_W-1:0]   s0_readdata,
  output logic                s0_readdatavalid,
  output logic [ADDR_W-1:0]   m0_address,
  output logic                m0_read,
  output logic                m0_write,
  output logic [DATA_W-1:0]   m0_writedata,
  output logic [DATA_W/8-1:0] m0_byteenable,
  output logic                m0_debugaccess,
  input  logic                m0_waitrequest,
  input  logic [DATA_W-1:0]   m0_readdata,
  input  logic                m0_readdatavalid
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned INCR  = beat_bytes(DATA_W);
  localparam int unsigned REM_W = cnt_width(burst_max(BURST_W));
  localparam int unsigned CNT_W = cnt_width(MAX_PENDING);

  state_e             state_q, state_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [BE_W-1:0]    be_q, be_d;
  logic               dbg_q, dbg_d;
  logic               m0_write_q, m0_write_d;
  logic               m0_read_q, m0_read_d;
  logic [DATA_W-1:0]  rdata_q;
  logic               rdv_q;

  logic [REM_W-1:0]   first_cnt;
  logic               rd_accept;
  logic [CNT_W-1:0]   pend_cnt;
  logic               limit_next;

  // A zero burstcount is handled as a single beat.
  assign first_cnt = (s0_burstcount == '0) ? REM_W'(1) : REM_W'(s0_burstcount);
  assign rd_accept = m0_read_q && !m0_waitrequest;

  avmm_pending_counter #(
    .MAX_PENDING (MAX_PENDING)
  ) u_pend (
    .clk_i          (clk_clk),
    .rst_i          (reset_reset),
    .inc_i          (rd_accept),
    .dec_i          (m0_readdatavalid),
    .count_o        (pend_cnt),
    .limit_next_c_o (limit_next)
  );

  // Next-state and next-output decode for the burst sequencer.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    dbg_d      = dbg_q;
    m0_write_d = 1'b0;
    m0_read_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (s0_write) begin
          addr_d     = s0_address;
          rem_d      = first_cnt;
          dbg_d      = s0_debugaccess;
          wdata_d    = s0_writedata;
          be_d       = s0_byteenable;
          m0_write_d = 1'b1;
          state_d    = ST_WR_BEAT;
        end else if (s0_read) begin
          addr_d    = s0_address;
          rem_d     = first_cnt;
          dbg_d     = s0_debugaccess;
          m0_read_d = !limit_next;
          state_d   = ST_RD_ISSUE;
        end
      end
      ST_WR_BEAT: begin
        m0_write_d = 1'b1;
        if (!m0_waitrequest) begin
          m0_write_d = 1'b0;
          rem_d      = rem_q - REM_W'(1);
          addr_d     = addr_q + ADDR_W'(INCR);
          state_d    = (rem_q == REM_W'(1)) ? ST_IDLE : ST_WR_WAIT;
        end
      end
      ST_WR_WAIT: begin
        if (s0_write) begin
          wdata_d    = s0_writedata;
          be_d       = s0_byteenable;
          m0_write_d = 1'b1;
          state_d    = ST_WR_BEAT;
        end
      end
      ST_RD_ISSUE: begin
        if (rd_accept) begin
          rem_d  = rem_q - REM_W'(1);
          addr_d = addr_q + ADDR_W'(INCR);
          if (rem_q == REM_W'(1)) state_d = ST_RD_DRAIN;
        end
        // Look ahead at next cycle's count so the registered strobe honours the limit.
        m0_read_d = (state_d == ST_RD_ISSUE) && !limit_next;
      end
      ST_RD_DRAIN: begin
        if (pend_cnt == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer state and registered master-side command.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q    <= ST_IDLE;
      rem_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      dbg_q      <= 1'b0;
      m0_write_q <= 1'b0;
      m0_read_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      dbg_q      <= dbg_d;
      m0_write_q <= m0_write_d;
      m0_read_q  <= m0_read_d;
    end
  end

  // Read return path: one register stage, forwarded in every state.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      rdata_q <= '0;
      rdv_q   <= 1'b0;
    end else begin
      rdata_q <= m0_readdata;
      rdv_q   <= m0_readdatavalid;
    end
  end

  assign s0_waitrequest   = reset_reset || !((state_q == ST_IDLE) || (state_q == ST_WR_WAIT));
  assign s0_readdata      = rdata_q;
  assign s0_readdatavalid = rdv_q;
  assign m0_address       = addr_q;
  assign m0_read          = m0_read_q;
  assign m0_write         = m0_write_q;
  assign m0_writedata     = wdata_q;
  assign m0_byteenable    = be_q;
  assign m0_debugaccess   = dbg_q;

endmodule

// File: doc/avmm_burst_bridge.md
# avmm_burst_bridge

Parametrised Avalon-MM bridge between the Nios system's exported bridge master and the FIR register/coefficient fabric. It accepts bursting reads and writes on its slave side and replays them as single-beat transfers on its master side, with incrementing addresses. It bounds outstanding reads to a configurable limit. It replaces the fixed 10-bit/32-bit, burstcount-1 export with a width-, burst- and pipelining-configurable stage.

## Interface

- ADDR_W, 10, byte address width, both sides
- DATA_W, 32, data width; multiple of 8
- BURST_W, 4, slave burstcount width; legal counts 1..2^(BURST_W-1)
- MAX_PENDING, 4, maximum master-side reads in flight (≥1)

- clk_clk  in  1  single clock
- reset_reset  in  1  asynchronous, active-high reset
- s0_address  in  ADDR_W  burst start byte address
- s0_burstcount  in  BURST_W  beats in burst
- s0_read / s0_write  in  1  command strobes (mutually exclusive)
- s0_writedata  in  DATA_W  write beat
- s0_byteenable  in  DATA_W/8  beat byte enables
- s0_debugaccess  in  1  debug qualifier, latched per burst
- s0_waitrequest  out  1  stall
- s0_readdata  out  DATA_W  read beat
- s0_readdatavalid  out  1  read beat valid
- m0_address  out  ADDR_W  single-beat address
- m0_read / m0_write  out  1  strobes
- m0_writedata  out  DATA_W; m0_byteenable  out  DATA_W/8; m0_debugaccess  out  1
- m0_waitrequest  in  1; m0_readdata  in  DATA_W; m0_readdatavalid  in  1

## Operation

- States: IDLE, WR_BEAT, WR_WAIT, RD_ISSUE, RD_DRAIN.
- IDLE: s0_waitrequest=0.
  - s0_write latches address, burstcount, debugaccess and first beat data/byteenable, then goes to WR_BEAT.
  - s0_read latches address, burstcount and debugaccess, then goes to RD_ISSUE.
  - Burstcount 0 is treated as 1.
- WR_BEAT: m0_write=1 with the latched beat; s0_waitrequest=1.
  - On accept (m0_waitrequest=0), decrement remaining and advance address by DATA_W/8.
  - If remaining was 1, go to IDLE; otherwise go to WR_WAIT.
- WR_WAIT: s0_waitrequest=0.
  - On s0_write, latch the beat and go to WR_BEAT.
  - s0_address and s0_burstcount are ignored mid-burst.
- RD_ISSUE: m0_read=1 while remaining>0 and pending<MAX_PENDING.
  - Each accept decrements remaining, advances address and increments pending.
  - When the last read is accepted, go to RD_DRAIN.
- RD_DRAIN: wait until pending reaches 0, then go to IDLE.
- s0_waitrequest=1 in RD_ISSUE and RD_DRAIN.
- Pending counter: +1 on m0 read accept, −1 on m0_readdatavalid; simultaneous events leave it unchanged; it saturates at 0.
- Read return: s0_readdata/s0_readdatavalid are m0_readdata/m0_readdatavalid registered once, in all states. Unsolicited beats are forwarded.
- Address arithmetic: modulo 2^ADDR_W, so wrap-around is silent.

## Timing

- Reset values: state IDLE, pending 0, m0_read=0, m0_write=0, m0_address=0, s0_readdatavalid=0, s0_readdata=0. s0_waitrequest=1 while reset_reset is high.
- Write: first m0_write the cycle after slave acceptance. Zero-wait master gives 2 cycles per beat.
- Read: first m0_read the cycle after acceptance. Back-to-back issue up to MAX_PENDING.
- Read return latency: exactly 1 cycle from m0_readdatavalid to s0_readdatavalid.
- Pending limit uses the registered count. At pending=MAX_PENDING, m0_read stays low that cycle even if m0_readdatavalid is high.
- m0 outputs are registered and held stable while m0_waitrequest=1.
- Reset mid-operation: abort to IDLE and clear pending. Late returns are forwarded as unsolicited.

## Structure

- Package avmm_bridge_pkg holds:
  - the state enum;
  - constant/function for beat byte increment (DATA_W/8);
  - function for the BURST_W maximum count.
- Sub-module avmm_pending_counter: saturating up/down counter with limit flag, parametrised by MAX_PENDING.

## Test plan

- Write burst addr 0x100, count 4, data 0xA0..0xA3, zero-wait master -> m0_write at 0x100/0x104/0x108/0x10C with matching data; back to IDLE after 4 accepts.
- Write count 2 with m0_waitrequest high for 3 cycles on beat 0 -> m0_address/m0_writedata held stable; s0_waitrequest=1 throughout.
- Read count 8, MAX_PENDING=4, readdatavalid delayed 5 cycles -> at most 4 reads outstanding; 8 s0_readdatavalid beats in order, each 1 cycle after its m0 beat.
- Read at addr 0x3FC, count 2 (ADDR_W=10) -> m0 addresses 0x3FC then 0x000.
- Burstcount 0 write -> exactly one m0_write.
- reset_reset asserted mid read with 3 pending -> outputs at reset values asynchronously. After release: IDLE, s0_waitrequest=0, pending=0; a late returned beat is forwarded once.
